// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall/flush control and the load-use hazard check.
// Optional macro ID_EX_PERF_CNT_EN adds saturating bubble and stall counters.
module id_ex_pipe_reg #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_read_data1,
  input  logic [XLEN-1:0] id_read_data2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [3:0]      id_funct,
  input  logic [1:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_read_data1,
  output logic [XLEN-1:0] ex_read_data2,
  output logic [XLEN-1:0] ex_imm,
  output logic [REGW-1:0] ex_rs1,
  output logic [REGW-1:0] ex_rs2,
  output logic [REGW-1:0] ex_rd,
  output logic [3:0]      ex_funct,
  output logic [1:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            load_use_hazard
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]     bubble_count,
  output logic [31:0]     stall_count
`endif
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_read_data1;
  logic [XLEN-1:0] r_read_data2;
  logic [XLEN-1:0] r_imm;
  logic [REGW-1:0] r_rs1;
  logic [REGW-1:0] r_rs2;
  logic [REGW-1:0] r_rd;
  logic [3:0]      r_funct;
  logic [1:0]      r_alu_op;
  logic            r_alu_src;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_reg_write;
  logic            r_mem_to_reg;
  logic            r_branch;

  // Bubbles (reset/flush) clear everything; an invalid ID slot keeps its data but drops all control.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_read_data1 <= '0;
      r_read_data2 <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_funct      <= '0;
      r_alu_op     <= '0;
      r_alu_src    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
    end else if (!stall) begin
      r_valid      <= id_valid;
      r_pc         <= id_pc;
      r_read_data1 <= id_read_data1;
      r_read_data2 <= id_read_data2;
      r_imm        <= id_imm;
      r_rs1        <= id_rs1;
      r_rs2        <= id_rs2;
      r_rd         <= id_rd;
      r_funct      <= id_funct;
      r_alu_op     <= id_valid ? id_alu_op : 2'b00;
      r_alu_src    <= id_valid & id_alu_src;
      r_mem_read   <= id_valid & id_mem_read;
      r_mem_write  <= id_valid & id_mem_write;
      r_reg_write  <= id_valid & id_reg_write;
      r_mem_to_reg <= id_valid & id_mem_to_reg;
      r_branch     <= id_valid & id_branch;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_read_data1 = r_read_data1;
  assign ex_read_data2 = r_read_data2;
  assign ex_imm        = r_imm;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_funct      = r_funct;
  assign ex_alu_op     = r_alu_op;
  assign ex_alu_src    = r_alu_src;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_branch     = r_branch;

  // Deliberately not gated by stall: the hazard unit needs the request while it is holding IF/ID.
  logic w_rd_match;
  assign w_rd_match      = (r_rd == id_rs1) || (r_rd == id_rs2);
  assign load_use_hazard = r_valid && r_mem_read && (r_rd != '0) && w_rd_match && id_valid;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_count;
  logic [31:0] r_stall_count;
  logic        w_bubble_evt;
  logic        w_stall_evt;

  assign w_bubble_evt = flush || (!stall && !id_valid);
  assign w_stall_evt  = stall && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_count <= '0;
      r_stall_count  <= '0;
    end else begin
      if (w_bubble_evt && (r_bubble_count != 32'hFFFF_FFFF))
        r_bubble_count <= r_bubble_count + 32'd1;
      if (w_stall_evt && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign bubble_count = r_bubble_count;
  assign stall_count  = r_stall_count;
`else
  // Counters are compiled out; the register set alone defines the block.
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a reference model pushes expected EX state per edge,
// which is popped and compared after the edge.
module tb_id_ex_pipe_reg;

  localparam int XLEN = 64;
  localparam int REGW = 5;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [3:0]      funct;
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            branch;
  } ex_t;

  logic            clk = 1'b0;
  logic            reset, stall, flush, id_valid;
  logic [XLEN-1:0] id_pc, id_read_data1, id_read_data2, id_imm;
  logic [REGW-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]      id_funct;
  logic [1:0]      id_alu_op;
  logic            id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_read_data1, ex_read_data2, ex_imm;
  logic [REGW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0]      ex_funct;
  logic [1:0]      ex_alu_op;
  logic            ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;
  logic            load_use_hazard;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]     bubble_count, stall_count;
`endif

  int  errors = 0;
  int  checks = 0;
  ex_t mdl;
  ex_t sb_q[$];

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .load_use_hazard(load_use_hazard)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_count(bubble_count), .stall_count(stall_count)
`endif
  );

  function automatic ex_t observe();
    ex_t o;
    o.valid = ex_valid;       o.pc = ex_pc;             o.rd1 = ex_read_data1;
    o.rd2 = ex_read_data2;    o.imm = ex_imm;           o.rs1 = ex_rs1;
    o.rs2 = ex_rs2;           o.rd = ex_rd;             o.funct = ex_funct;
    o.alu_op = ex_alu_op;     o.alu_src = ex_alu_src;   o.mem_read = ex_mem_read;
    o.mem_write = ex_mem_write; o.reg_write = ex_reg_write;
    o.mem_to_reg = ex_mem_to_reg; o.branch = ex_branch;
    return o;
  endfunction

  function automatic ex_t model_next();
    ex_t n;
    if (reset || flush) n = '0;
    else if (stall) n = mdl;
    else begin
      n.valid = id_valid;  n.pc = id_pc;  n.rd1 = id_read_data1;  n.rd2 = id_read_data2;
      n.imm = id_imm;  n.rs1 = id_rs1;  n.rs2 = id_rs2;  n.rd = id_rd;  n.funct = id_funct;
      n.alu_op     = id_valid ? id_alu_op : 2'b00;
      n.alu_src    = id_valid ? id_alu_src : 1'b0;
      n.mem_read   = id_valid ? id_mem_read : 1'b0;
      n.mem_write  = id_valid ? id_mem_write : 1'b0;
      n.reg_write  = id_valid ? id_reg_write : 1'b0;
      n.mem_to_reg = id_valid ? id_mem_to_reg : 1'b0;
      n.branch     = id_valid ? id_branch : 1'b0;
    end
    return n;
  endfunction

  function automatic logic model_hazard();
    return mdl.valid && mdl.mem_read && (mdl.rd != 0) && ((mdl.rd == id_rs1) || (mdl.rd == id_rs2)) && id_valid;
  endfunction

  // Push the expected state, clock once, then sample 1 time unit after the edge.
  task automatic tick();
    mdl = model_next();
    sb_q.push_back(mdl);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] fn, input logic [1:0] op,
                               input logic [5:0] ctrl, input logic [REGW-1:0] rd,
                               input logic [REGW-1:0] rs1, input logic [REGW-1:0] rs2);
    id_valid = v;  id_funct = fn;  id_alu_op = op;
    {id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch} = ctrl;
    id_rd = rd;  id_rs1 = rs1;  id_rs2 = rs2;
    id_pc = {$urandom, $urandom};  id_read_data1 = {$urandom, $urandom};
    id_read_data2 = {$urandom, $urandom};  id_imm = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    ex_t e;
    reset = 1'b1;  stall = 1'b0;  flush = 1'b0;
    id_valid = 1'b1;  id_pc = '1;  id_read_data1 = '1;  id_read_data2 = '1;  id_imm = '1;
    id_rs1 = '1;  id_rs2 = '1;  id_rd = '1;  id_funct = '1;  id_alu_op = '1;
    {id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch} = '1;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if (observe() !== e) begin
        errors++;
        $display("[TB] FAIL reset_state: got %h expected %h", observe(), e);
      end
      checks++;
      if (load_use_hazard !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hazard: got %b expected 0", load_use_hazard);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_normal_load();
    ex_t e;
    applyStimulus(1'b1, 4'b1000, 2'b10, 6'b000100, 5'd7, 5'd1, 5'd2);
    id_read_data1 = 64'h5;
    tick();
    e = sb_q.pop_front();
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("[TB] FAIL normal_load: got %h expected %h", observe(), e);
    end
    checks++;
    if ({ex_funct, ex_alu_op, ex_reg_write, ex_read_data1, ex_rd, ex_valid} !== {4'b1000, 2'b10, 1'b1, 64'h5, 5'd7, 1'b1}) begin
      errors++;
      $display("[TB] FAIL normal_load_fields: got rd=%0d funct=%b op=%b v=%b", ex_rd, ex_funct, ex_alu_op, ex_valid);
    end
  endtask

  task automatic test_stall_hold();
    ex_t e;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'b0001, 2'b00, 6'b110000, 5'd9, 5'd3, 5'd4);
      tick();
      e = sb_q.pop_front();
      checks++;
      if (observe() !== e || ex_rd !== 5'd7 || ex_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold: got rd=%0d v=%b expected rd=7 v=1", ex_rd, ex_valid);
      end
    end
    stall = 1'b0;
    tick();
    e = sb_q.pop_front();
    checks++;
    if (observe() !== e || ex_rd !== 5'd9) begin
      errors++;
      $display("[TB] FAIL stall_release: got rd=%0d expected 9", ex_rd);
    end
  endtask

  task automatic test_flush_vs_stall();
    ex_t e;
    stall = 1'b1;  flush = 1'b1;
    applyStimulus(1'b1, 4'b0111, 2'b10, 6'b111111, 5'd12, 5'd13, 5'd14);
    tick();
    e = sb_q.pop_front();
    checks++;
    if (observe() !== e || observe() !== ex_t'(0)) begin
      errors++;
      $display("[TB] FAIL flush_vs_stall: got %h expected all zero", observe());
    end
    stall = 1'b0;  flush = 1'b0;
  endtask

  task automatic test_invalid_load();
    ex_t e;
    applyStimulus(1'b0, 4'b1101, 2'b11, 6'b111111, 5'd20, 5'd21, 5'd22);
    tick();
    e = sb_q.pop_front();
    checks++;
    if (observe() !== e || ex_rd !== 5'd20 || ex_alu_op !== 2'b00 || ex_mem_read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL invalid_load: got %h expected %h", observe(), e);
    end
  endtask

  task automatic test_load_use();
    ex_t e;
    applyStimulus(1'b1, 4'b0011, 2'b00, 6'b110110, 5'd5, 5'd0, 5'd0);
    tick();
    e = sb_q.pop_front();
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("[TB] FAIL load_use_setup: got %h expected %h", observe(), e);
    end
    stall = 1'b1;
    id_valid = 1'b1;  id_rs1 = 5'd1;  id_rs2 = 5'd5;  #1;
    checks++;
    if (load_use_hazard !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_use_rs2: got %b expected 1", load_use_hazard);
    end
    id_rs1 = 5'd6;  id_rs2 = 5'd6;  #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_use_nomatch: got %b expected 0", load_use_hazard);
    end
    id_rs1 = 5'd5;  id_valid = 1'b0;  #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_use_id_invalid: got %b expected 0", load_use_hazard);
    end
    stall = 1'b0;
    applyStimulus(1'b1, 4'b0011, 2'b00, 6'b110110, 5'd0, 5'd0, 5'd0);
    tick();
    e = sb_q.pop_front();
    id_rs1 = 5'd0;  id_rs2 = 5'd0;  id_valid = 1'b1;  #1;
    checks++;
    if (observe() !== e || load_use_hazard !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_use_rd0: got %b expected 0", load_use_hazard);
    end
  endtask

  task automatic test_reset_priority();
    ex_t e;
    applyStimulus(1'b1, 4'b0101, 2'b01, 6'b000001, 5'd8, 5'd9, 5'd10);
    tick();
    e = sb_q.pop_front();
    reset = 1'b1;  stall = 1'b1;  flush = 1'b1;
    tick();
    e = sb_q.pop_front();
    checks++;
    if (observe() !== e || ex_valid !== 1'b0 || ex_rd !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_priority: got %h expected %h", observe(), e);
    end
    reset = 1'b0;  stall = 1'b0;  flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    ex_t e;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom), 6'($urandom),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      #1;
      checks++;
      if (load_use_hazard !== model_hazard()) begin
        errors++;
        $display("[TB] FAIL b2b_hazard[%0d]: got %b expected %b", i, load_use_hazard, model_hazard());
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if (observe() !== e) begin
        errors++;
        $display("[TB] FAIL b2b_state[%0d]: got %h expected %h", i, observe(), e);
      end
    end
    stall = 1'b0;  flush = 1'b0;
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_perf();
    ex_t e;
    reset = 1'b1;  tick();  e = sb_q.pop_front();  reset = 1'b0;
    applyStimulus(1'b1, 4'b0, 2'b0, 6'b0, 5'd1, 5'd2, 5'd3);
    flush = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); e = sb_q.pop_front(); end
    flush = 1'b0;  stall = 1'b1;
    for (int i = 0; i < 2; i++) begin tick(); e = sb_q.pop_front(); end
    stall = 1'b0;  id_valid = 1'b0;
    tick();
    e = sb_q.pop_front();
    checks++;
    if (bubble_count !== 32'd5 || stall_count !== 32'd2) begin
      errors++;
      $display("[TB] FAIL perf_counts: got bubble=%0d stall=%0d expected 5 and 2", bubble_count, stall_count);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;  stall = 1'b0;  flush = 1'b0;
    mdl = '0;
    #2;
    test_reset();
    test_normal_load();
    test_stall_hold();
    test_flush_vs_stall();
    test_invalid_load();
    test_load_use();
    test_reset_priority();
    test_back_to_back();
`ifdef ID_EX_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
